// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: slave and master FSM encodings, request record
// and the address-decode helper used by the slave memory.
package wb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} slv_state_t;

    typedef enum logic [1:0] {M_IDLE, M_REQ, M_HOLD} mst_state_t;

    localparam int         WORD_SHIFT = 2;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

    // Unsigned offset wraps for adr < base, so a single compare covers both ends.
    function automatic logic addr_ok(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
        return ((adr[1:0] & ALIGN_MASK) == 2'b00) && ((adr - base) < span);
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between one master and the slave memory.
interface wb_slave_mem_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_mem_bytes.sv
// Single-port DEPTH x 32 word store with per-byte write enables and
// asynchronous read.
module wb_mem_bytes #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; its contents after reset are don't-care.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone slave memory: latches one request, inserts WAIT_CYCLES wait states,
// then terminates with a single-cycle ack (valid) or err (bad address).
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    wb_slave_mem_if.slave bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
    localparam logic [3:0]  LAST    = 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    slv_state_t  state;
    wb_req_t     req;
    wb_req_t     cur;
    logic [3:0]  wait_cnt;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;
    logic [31:0] rd_data;
    logic        sample;
    logic        enter_resp;
    logic        cur_ok;
    logic [3:0]  byte_we;

    assign sample = bus.wb_cyc_i && bus.wb_stb_i;

    // In IDLE the live bus is the request being sampled; afterwards only the latched copy counts.
    always_comb begin
        // NOTE: default assignment first so no path leaves cur unassigned (no latch).
        cur = req;
        if (state == IDLE) begin
            cur.we  = bus.wb_we_i;
            cur.adr = bus.wb_adr_i;
            cur.dat = bus.wb_dat_i;
            cur.sel = bus.wb_sel_i;
        end
    end

    assign cur_ok     = addr_ok(cur.adr, BASE_ADDR, SPAN);
    assign enter_resp = ((state == IDLE) && sample && NO_WAIT)
                     || ((state == WAIT) && bus.wb_cyc_i && (wait_cnt == LAST));
    assign byte_we    = (enter_resp && cur.we && cur_ok) ? cur.sel : 4'b0000;

    wb_mem_bytes #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .addr  (cur.adr[WORD_SHIFT +: AW]),
        .we    (byte_we),
        .wdata (cur.dat),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            req      <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            ack_q <= enter_resp && cur_ok;
            err_q <= enter_resp && !cur_ok;
            dat_q <= (enter_resp && cur_ok && !cur.we) ? rd_data : '0;
            case (state)
                IDLE: begin
                    if (sample) begin
                        req      <= cur;
                        wait_cnt <= '0;
                        if (NO_WAIT) state <= RESP;
                        else         state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.wb_cyc_i) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem: three instances (1, 0 and 3 wait states,
// the last one relocated) driven from per-scenario tasks.
module tb_wb_slave_mem;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [31:0] model [3][16];

    logic        cyc_v [3];
    logic        stb_v [3];
    logic        we_v  [3];
    logic [31:0] adr_v [3];
    logic [31:0] dat_v [3];
    logic [3:0]  sel_v [3];
    logic        ack_v [3];
    logic        err_v [3];
    logic [31:0] rdat_v[3];

    wb_slave_mem_if bus_a ();
    wb_slave_mem_if bus_b ();
    wb_slave_mem_if bus_c ();

    assign {bus_a.wb_cyc_i, bus_a.wb_stb_i, bus_a.wb_we_i} = {cyc_v[0], stb_v[0], we_v[0]};
    assign {bus_a.wb_adr_i, bus_a.wb_dat_i, bus_a.wb_sel_i} = {adr_v[0], dat_v[0], sel_v[0]};
    assign {bus_b.wb_cyc_i, bus_b.wb_stb_i, bus_b.wb_we_i} = {cyc_v[1], stb_v[1], we_v[1]};
    assign {bus_b.wb_adr_i, bus_b.wb_dat_i, bus_b.wb_sel_i} = {adr_v[1], dat_v[1], sel_v[1]};
    assign {bus_c.wb_cyc_i, bus_c.wb_stb_i, bus_c.wb_we_i} = {cyc_v[2], stb_v[2], we_v[2]};
    assign {bus_c.wb_adr_i, bus_c.wb_dat_i, bus_c.wb_sel_i} = {adr_v[2], dat_v[2], sel_v[2]};
    assign ack_v[0] = bus_a.wb_ack_o;  assign err_v[0] = bus_a.wb_err_o;  assign rdat_v[0] = bus_a.wb_dat_o;
    assign ack_v[1] = bus_b.wb_ack_o;  assign err_v[1] = bus_b.wb_err_o;  assign rdat_v[1] = bus_b.wb_dat_o;
    assign ack_v[2] = bus_c.wb_ack_o;  assign err_v[2] = bus_c.wb_err_o;  assign rdat_v[2] = bus_c.wb_dat_o;

    wb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    wb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    wb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_1000))
        u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    // Expected response for a request; valid writes update the reference model.
    function automatic exp_t predict(input int d, input logic we, input logic [31:0] adr,
                                     input logic [31:0] dat, input logic [3:0] sel);
        exp_t        e;
        logic [31:0] off;
        off    = adr - base_of(d);
        e.err  = (adr[1:0] != 2'b00) || (off >= 32'h40);
        e.data = '0;
        e.lat  = 8'(wait_of(d) + 1);
        if (!e.err && !we) e.data = model[d][off[5:2]];
        if (!e.err && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[d][off[5:2]][8*b +: 8] = dat[8*b +: 8];
        end
        return e;
    endfunction

    task automatic do_req(input int d, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input string name);
        exp_t got;
        int   lat;
        bit   done;
        @(negedge clk);
        sb.push_back(predict(d, we, adr, dat, sel));
        cyc_v[d] = 1'b1; stb_v[d] = 1'b1; we_v[d] = we;
        adr_v[d] = adr;  dat_v[d] = dat;  sel_v[d] = sel;
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                stb_v[d] = 1'b0; we_v[d] = ~we;
                adr_v[d] = $urandom; dat_v[d] = $urandom; sel_v[d] = 4'($urandom);
            end
            if (ack_v[d] || err_v[d]) begin
                done = 1'b1;
                got  = sb.pop_front();
                cyc_v[d] = 1'b0;
                total++;
                if (lat !== int'(got.lat)) begin
                    $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, got.lat); bad++;
                end
                total++;
                if (err_v[d] !== got.err) begin
                    $display("FAIL %s err: got %b, want %b", name, err_v[d], got.err); bad++;
                end
                total++;
                if (ack_v[d] !== !got.err) begin
                    $display("FAIL %s ack: got %b, want %b", name, ack_v[d], !got.err); bad++;
                end
                total++;
                if (rdat_v[d] !== got.data) begin
                    $display("FAIL %s dat_o: got %h, want %h", name, rdat_v[d], got.data); bad++;
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout: no ack/err within 20 cycles", name);
            got = sb.pop_front();
            cyc_v[d] = 1'b0; stb_v[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({ack_v[d], err_v[d], rdat_v[d]} !== 34'd0) begin
                $display("FAIL reset_outputs dut%0d: got ack=%b err=%b dat=%h, want all 0",
                         d, ack_v[d], err_v[d], rdat_v[d]); bad++;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_req(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, "wr_08");
        do_req(0, 1'b0, 32'h08, 32'h0,        4'hF, "rd_08");
    endtask

    task automatic test_byte_enable();
        do_req(0, 1'b1, 32'h08, 32'h000000AA, 4'b0001, "wr_08_sel1");
        do_req(0, 1'b0, 32'h08, 32'h0,        4'hF,    "rd_08_sel1");
        do_req(0, 1'b1, 32'h08, 32'h12345678, 4'b0000, "wr_08_sel0");
        do_req(0, 1'b0, 32'h08, 32'h0,        4'hF,    "rd_08_sel0");
        do_req(0, 1'b1, 32'h3C, 32'h01020304, 4'hF,    "wr_3c_full");
        do_req(0, 1'b1, 32'h3C, 32'hF0E0D0C0, 4'b1010, "wr_3c_sel_a");
        do_req(0, 1'b0, 32'h3C, 32'h0,        4'hF,    "rd_3c");
    endtask

    task automatic test_errors();
        do_req(0, 1'b0, 32'h40,       32'h0,        4'hF, "rd_40_range");
        do_req(0, 1'b1, 32'h05,       32'h55555555, 4'hF, "wr_05_misalign");
        do_req(0, 1'b1, 32'hFFFF_FFFC, 32'h66666666, 4'hF, "wr_top_range");
        do_req(0, 1'b0, 32'h08,       32'h0,        4'hF, "rd_08_after_err");
        do_req(2, 1'b0, 32'h08,       32'h0,        4'hF, "rd_below_base");
    endtask

    task automatic test_ignore_stb();
        int seen = 0;
        @(negedge clk);
        cyc_v[0] = 1'b0; stb_v[0] = 1'b1; we_v[0] = 1'b1;
        adr_v[0] = 32'h08; dat_v[0] = 32'hFFFFFFFF; sel_v[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_v[0] || err_v[0]) seen++;
        end
        stb_v[0] = 1'b0;
        total++;
        if (seen !== 0) begin
            $display("FAIL stb_without_cyc: got %0d responses, want 0", seen); bad++;
        end
        do_req(0, 1'b0, 32'h08, 32'h0, 4'hF, "rd_08_after_stb");
    endtask

    task automatic test_abort();
        int seen = 0;
        do_req(2, 1'b1, 32'h1010, 32'hAAAA5555, 4'hF, "wr_1010");
        @(negedge clk);
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b1;
        adr_v[2] = 32'h1010; dat_v[2] = 32'h12345678; sel_v[2] = 4'hF;
        @(negedge clk);
        cyc_v[2] = 1'b0; stb_v[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_v[2] || err_v[2]) seen++;
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL abort_response: got %0d responses, want 0", seen); bad++;
        end
        do_req(2, 1'b0, 32'h1010, 32'h0, 4'hF, "rd_1010_after_abort");
    endtask

    task automatic test_back_to_back();
        logic        we_l [3];
        logic [31:0] adr_l[3];
        logic [31:0] dat_l[3];
        logic [5:0]  pattern = '0;
        exp_t        got;
        int          acks = 0;
        int          idx  = 0;
        we_l[0] = 1'b1; adr_l[0] = 32'h00; dat_l[0] = 32'h11111111;
        we_l[1] = 1'b1; adr_l[1] = 32'h04; dat_l[1] = 32'h22222222;
        we_l[2] = 1'b0; adr_l[2] = 32'h00; dat_l[2] = 32'h0;
        @(negedge clk);
        sb.push_back(predict(1, we_l[0], adr_l[0], dat_l[0], 4'hF));
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; we_v[1] = we_l[0];
        adr_v[1] = adr_l[0]; dat_v[1] = dat_l[0]; sel_v[1] = 4'hF;
        idx = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) pattern[c] = ack_v[1];
            if (ack_v[1]) begin
                acks++;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_extra_ack: got ack at cycle %0d, want none", c); bad++;
                end else begin
                    got = sb.pop_front();
                    if (rdat_v[1] !== got.data) begin
                        $display("FAIL b2b_dat_o: got %h, want %h", rdat_v[1], got.data); bad++;
                    end
                end
                if (idx < 3) begin
                    sb.push_back(predict(1, we_l[idx], adr_l[idx], dat_l[idx], 4'hF));
                    we_v[1] = we_l[idx]; adr_v[1] = adr_l[idx]; dat_v[1] = dat_l[idx];
                    idx++;
                end else begin
                    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
                end
            end
        end
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
        total++;
        if (pattern !== 6'b010101) begin
            $display("FAIL b2b_ack_pattern: got %b, want 010101", pattern); bad++;
        end
        total++;
        if (acks !== 3) begin
            $display("FAIL b2b_ack_count: got %0d, want 3", acks); bad++;
        end
        do_req(1, 1'b0, 32'h04, 32'h0, 4'hF, "rd_04_after_b2b");
    endtask

    task automatic test_reset_mid();
        do_req(0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, "wr_0c");
        @(negedge clk);
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b0; adr_v[0] = 32'h0C; sel_v[0] = 4'hF;
        @(negedge clk);
        stb_v[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({ack_v[0], rdat_v[0]} !== {1'b1, model[0][3]}) begin
            $display("FAIL pre_reset_ack: got ack=%b dat=%h, want ack=1 dat=%h",
                     ack_v[0], rdat_v[0], model[0][3]); bad++;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ack_v[0], err_v[0], rdat_v[0]} !== 34'd0) begin
            $display("FAIL async_reset_resp: got ack=%b err=%b dat=%h, want all 0",
                     ack_v[0], err_v[0], rdat_v[0]); bad++;
        end
        @(negedge clk);
        rst = 1'b0; cyc_v[0] = 1'b0;
        @(negedge clk);
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b1;
        adr_v[0] = 32'h0C; dat_v[0] = 32'h0BADF00D; sel_v[0] = 4'hF;
        @(negedge clk);
        stb_v[0] = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({ack_v[0], err_v[0], rdat_v[0]} !== 34'd0) begin
            $display("FAIL reset_in_wait: got ack=%b err=%b dat=%h, want all 0",
                     ack_v[0], err_v[0], rdat_v[0]); bad++;
        end
        @(negedge clk);
        total++;
        if ({ack_v[0], err_v[0]} !== 2'b00) begin
            $display("FAIL reset_held: got ack=%b err=%b, want 0 0", ack_v[0], err_v[0]); bad++;
        end
        rst = 1'b0; cyc_v[0] = 1'b0;
        do_req(0, 1'b0, 32'h0C, 32'h0,        4'hF, "rd_0c_after_rst");
        do_req(0, 1'b1, 32'h0C, 32'h600DF00D, 4'hF, "wr_0c_after_rst");
        do_req(0, 1'b0, 32'h0C, 32'h0,        4'hF, "rd_0c_final");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            cyc_v[d] = 1'b0; stb_v[d] = 1'b0; we_v[d] = 1'b0;
            adr_v[d] = '0;   dat_v[d] = '0;   sel_v[d] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_ignore_stb();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() !== 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size()); bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words; power of two, 2..256.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before the response; range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wb_cyc_i  input  1  bus cycle active.
REQ-007 SHALL have port wb_stb_i  input  1  strobe; a request is cyc&stb.
REQ-008 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port wb_adr_i  input  32  byte address.
REQ-010 SHALL have port wb_dat_i  input  32  write data.
REQ-011 SHALL have port wb_sel_i  input  4  byte enables; bit n covers bits [8n+7:8n].
REQ-012 SHALL have port wb_dat_o  output  32  read data.
REQ-013 SHALL have port wb_ack_o  output  1  normal termination.
REQ-014 SHALL have port wb_err_o  output  1  error termination.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-016 SHALL, in IDLE with cyc&stb high at a clock edge, latch we, adr, dat and sel, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 SHALL, in WAIT, count exactly WAIT_CYCLES edges, then go to RESP.
REQ-018 SHALL assert ack or err for exactly one cycle in RESP, then return to IDLE; ack high = WAIT_CYCLES+1 cycles after the first cycle in which the request is sampled.
REQ-019 SHALL treat the request as valid when adr is in BASE_ADDR..BASE_ADDR+4*DEPTH-1 and adr[1:0]==0; otherwise assert err (never ack) and perform no access.
REQ-020 SHALL index words by adr[2 +: log2(DEPTH)] of the latched address.
REQ-021 SHALL commit a valid write on the edge entering RESP, updating only bytes whose sel bit is 1; sel==0 SHALL still ack without changing memory.
REQ-022 SHALL drive wb_dat_o with the addressed word during the ack cycle of a valid read, and 0 in all other cycles, including err and write cycles.
REQ-023 SHALL use the latched request fields only; changes to inputs after the request is sampled SHALL have no effect.
REQ-024 SHALL abort when cyc drops while in WAIT: return to IDLE next edge, with no ack, no err and no write.
REQ-025 SHALL ignore stb while cyc is low.
REQ-026 SHALL allow back-to-back requests: if cyc&stb is high in the cycle after RESP (IDLE), that is sampled as a new request; a master holding stb through the ack cycle SHALL NOT cause a duplicate access.
REQ-027 SHALL never assert ack and err together.

Reset
REQ-028 SHALL, on rst, force state IDLE, wait counter 0, and wb_ack_o=0, wb_err_o=0, wb_dat_o=0 immediately.
REQ-029 SHALL, on reset mid-transaction, drop any pending write with no response.
REQ-030 SHALL leave memory contents undefined after reset; no clear is required.

Structure
REQ-031 SHALL place the FSM state encoding and the error/decode helper constants in shared package wb_pkg, alongside the master's state definitions.
REQ-032 SHALL implement storage as sub-module wb_mem_bytes: DEPTH x 32 array, per-byte write enable, single port, asynchronous read.

Verification
REQ-033 SHALL verify a write of 0xDEADBEEF to 0x08 with sel=4'hF, then a read of 0x08: ack 2 cycles after each request (WAIT_CYCLES=1), dat_o=0xDEADBEEF on the read ack.
REQ-034 SHALL verify a write of 0x000000AA to 0x08 with sel=4'b0001 over 0xDEADBEEF: a later read returns 0xDEADBEAA.
REQ-035 SHALL verify a read of 0x40 (out of range, DEPTH=16) and a write to 0x05 (misaligned): err pulses one cycle, ack stays 0, memory is unchanged.
REQ-036 SHALL verify cyc dropped in WAIT with WAIT_CYCLES=3 on a write: no ack, no err, and a later read shows the old data.
REQ-037 SHALL verify stb held through 3 consecutive requests with WAIT_CYCLES=0: ack every second cycle, exactly three accesses.
REQ-038 SHALL verify rst asserted during WAIT of a write: outputs are 0 immediately, the write is not committed, and the next request completes normally.
